// File: rtl/seg_pkg.sv
// Shared mode codes, segment glyph constants and helpers for the 7-segment display controller.
package seg_pkg;

  // Display modes as presented on the load interface.
  typedef enum logic [1:0] {
    MODE_PLAIN = 2'd0,
    MODE_NEG   = 2'd1,
    MODE_ERR   = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  // Sequential double-dabble converter states.
  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  localparam int unsigned BCD_DIGIT_W = 4;

  // Active-low {dp,g,f,e,d,c,b,a} patterns.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;

  // Active-low {g..a} glyph for a BCD digit; non-decimal codes show nothing.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // 10^n, used to derive the overflow limits at elaboration time.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Load handshake and pin-side outputs of the 7-segment display controller.
interface seg_display_ctrl_if #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DATA_W   = 14
) ();
  import seg_pkg::*;

  logic                load;
  logic [DATA_W-1:0]   value;
  mode_e               mode;
  logic [N_DIGITS-1:0] dp_mask;
  logic                lz_blank;
  logic                busy;
  logic                overflow;
  logic [N_DIGITS-1:0] anodes;
  logic [7:0]          segments;

  // Producer of display requests (ALU / switch logic side).
  modport master (
    output load, value, mode, dp_mask, lz_blank,
    input  busy, overflow, anodes, segments
  );

  // The display controller itself.
  modport slave (
    input  load, value, mode, dp_mask, lz_blank,
    output busy, overflow, anodes, segments
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift/add-3 step per clock, then a one-cycle done phase.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DATA_W   = 14
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic                            start_i,
  input  logic [DATA_W-1:0]               bin_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd_o
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * N_DIGITS;
  localparam int unsigned SH_W  = DATA_W + BCD_W;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  conv_state_e       state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // One double-dabble iteration: correct every BCD digit >= 5, then shift left.
  function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] r;
    logic [3:0]      d;
    r = s;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      d = r[DATA_W + BCD_DIGIT_W*i +: BCD_DIGIT_W];
      if (d >= 4'd5) begin
        r[DATA_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] = d + 4'd3;
      end
    end
    return {r[SH_W-2:0], 1'b0};
  endfunction

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= CONV_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: load on start, DATA_W shift steps, then a done cycle while busy stays high.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      CONV_IDLE: begin
        if (start_i) begin
          sh_d    = {BCD_W'(0), bin_i};
          cnt_d   = CNT_W'(DATA_W);
          busy_d  = 1'b1;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        sh_d  = dabble_step(sh_q);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done_d  = 1'b1;
          state_d = CONV_DONE;
        end
      end
      CONV_DONE: begin
        busy_d  = 1'b0;
        state_d = CONV_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = CONV_IDLE;
      end
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = sh_q[SH_W-1 -: BCD_W];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed common-anode 7-segment driver: load handshake, BCD conversion, overflow, image build and scan.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DATA_W   = 14,
  parameter int unsigned DIV_W    = 12
) (
  input  logic               Clk,
  input  logic               Rst_n,
  seg_display_ctrl_if.slave  bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * N_DIGITS;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam logic [63:0] LIM_PLAIN = pow10(N_DIGITS) - 64'd1;
  localparam logic [63:0] LIM_NEG   = pow10(N_DIGITS - 1) - 64'd1;

  logic                conv_busy;
  logic                conv_done;
  logic [BCD_W-1:0]    conv_bcd;
  logic                accept_c;

  // Request captured at load, held until the converter commits.
  mode_e               pend_mode_q, pend_mode_d;
  logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                pend_lz_q, pend_lz_d;
  logic                pend_ovf_q, pend_ovf_d;

  // Image currently on the display.
  logic [BCD_W-1:0]    disp_bcd_q, disp_bcd_d;
  mode_e               disp_mode_q, disp_mode_d;
  logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                disp_lz_q, disp_lz_d;
  logic                ovf_q, ovf_d;

  // Scan machinery.
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]          seg_q, seg_d;

  // Image-build intermediates.
  logic [IDX_W-1:0]    msnz;
  logic [IDX_W-1:0]    minus_pos;
  logic [3:0]          digit;
  logic                dp_bit;
  logic                blanked;
  logic [6:0]          seg7;

  assign accept_c = bus.load && !conv_busy;

  bin2bcd_seq #(
    .N_DIGITS (N_DIGITS),
    .DATA_W   (DATA_W)
  ) u_bin2bcd (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .start_i (accept_c),
    .bin_i   (bus.value),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // All controller state; reset blanks the display and aborts conversion.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      pend_mode_q <= MODE_BLANK;
      pend_dp_q   <= '0;
      pend_lz_q   <= 1'b0;
      pend_ovf_q  <= 1'b0;
      disp_bcd_q  <= '0;
      disp_mode_q <= MODE_BLANK;
      disp_dp_q   <= '0;
      disp_lz_q   <= 1'b0;
      ovf_q       <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      anodes_q    <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      pend_mode_q <= pend_mode_d;
      pend_dp_q   <= pend_dp_d;
      pend_lz_q   <= pend_lz_d;
      pend_ovf_q  <= pend_ovf_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_mode_q <= disp_mode_d;
      disp_dp_q   <= disp_dp_d;
      disp_lz_q   <= disp_lz_d;
      ovf_q       <= ovf_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      anodes_q    <= anodes_d;
      seg_q       <= seg_d;
    end
  end

  // Capture the request and its overflow verdict, then commit everything together when conversion ends.
  always_comb begin
    pend_mode_d = pend_mode_q;
    pend_dp_d   = pend_dp_q;
    pend_lz_d   = pend_lz_q;
    pend_ovf_d  = pend_ovf_q;
    disp_bcd_d  = disp_bcd_q;
    disp_mode_d = disp_mode_q;
    disp_dp_d   = disp_dp_q;
    disp_lz_d   = disp_lz_q;
    ovf_d       = ovf_q;
    if (accept_c) begin
      pend_mode_d = bus.mode;
      pend_dp_d   = bus.dp_mask;
      pend_lz_d   = bus.lz_blank;
      pend_ovf_d  = ((bus.mode == MODE_PLAIN) && (64'(bus.value) > LIM_PLAIN)) ||
                    ((bus.mode == MODE_NEG)   && (64'(bus.value) > LIM_NEG));
    end
    if (conv_done) begin
      disp_bcd_d  = conv_bcd;
      disp_mode_d = pend_ovf_q ? MODE_ERR : pend_mode_q;
      disp_dp_d   = pend_dp_q;
      disp_lz_d   = pend_lz_q;
      ovf_d       = pend_ovf_q;
    end
  end

  // Refresh divider and scan index; index advances on divider wrap and wraps at N_DIGITS-1.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (&div_q) begin
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Segment pattern for the next index, built from the next image so anodes and segments stay aligned.
  always_comb begin
    msnz      = '0;
    digit     = 4'd0;
    dp_bit    = 1'b0;
    seg7      = SEG_BLANK[6:0];
    for (int unsigned i = 1; i < N_DIGITS; i++) begin
      if (disp_bcd_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] != 4'd0) begin
        msnz = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        digit  = disp_bcd_d[BCD_DIGIT_W*i +: BCD_DIGIT_W];
        dp_bit = disp_dp_d[i];
      end
    end
    blanked   = disp_lz_d && (idx_d > msnz);
    minus_pos = disp_lz_d ? (msnz + IDX_W'(1)) : IDX_W'(N_DIGITS - 1);
    case (disp_mode_d)
      MODE_PLAIN: seg7 = blanked ? SEG_BLANK[6:0] : digit_to_seg(digit);
      MODE_NEG: begin
        if (idx_d == minus_pos) begin
          seg7 = SEG_MINUS[6:0];
        end else begin
          seg7 = blanked ? SEG_BLANK[6:0] : digit_to_seg(digit);
        end
      end
      MODE_ERR:   seg7 = (idx_d == '0) ? SEG_E[6:0] : digit_to_seg(4'd0);
      MODE_BLANK: seg7 = SEG_BLANK[6:0];
      default:    seg7 = SEG_BLANK[6:0];
    endcase
    seg_d    = {(disp_mode_d == MODE_BLANK) ? 1'b1 : ~dp_bit, seg7};
    anodes_d = ~(N_DIGITS'(1) << idx_d);
  end

  assign bus.busy     = conv_busy;
  assign bus.overflow = ovf_q;
  assign bus.anodes   = anodes_q;
  assign bus.segments = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: a 4-digit and a 6-digit instance exercised in turn.
module tb_seg_display_ctrl;
  import seg_pkg::*;

  typedef struct packed {
    logic        ovf;
    logic [63:0] segs;
  } exp_t;

  localparam logic [7:0] GLY [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic clk;
  logic rst_n;
  bit   sel;
  int   total;
  int   bad;
  exp_t sb [$];

  seg_display_ctrl_if #(.N_DIGITS(4), .DATA_W(14)) ifa ();
  seg_display_ctrl_if #(.N_DIGITS(6), .DATA_W(20)) ifb ();

  seg_display_ctrl #(.N_DIGITS(4), .DATA_W(14), .DIV_W(2)) dut_a (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (ifa.slave)
  );

  seg_display_ctrl #(.N_DIGITS(6), .DATA_W(20), .DIV_W(2)) dut_b (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected display from decimal arithmetic on the requested value.
  function automatic exp_t model(input int n, input longint v, input int m,
                                 input logic [7:0] dp, input bit lz);
    exp_t       e;
    longint     p;
    longint     q;
    longint     t;
    int         nd;
    int         mp;
    int         d;
    int         em;
    logic [7:0] b;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    e.ovf = ((m == 0) && (v > p - 1)) || ((m == 1) && (v > p / 10 - 1));
    em = e.ovf ? 2 : m;
    nd = 1;
    t  = v;
    while (t >= 10) begin
      t = t / 10;
      nd++;
    end
    mp = lz ? nd : n - 1;
    e.segs = '1;
    q = 1;
    for (int i = 0; i < n; i++) begin
      d = int'((v / q) % 10);
      q = q * 10;
      case (em)
        0, 1: begin
          b = (lz && i >= nd) ? 8'hFF : GLY[d];
          if (em == 1 && i == mp) b = 8'hBF;
        end
        2:       b = (i == 0) ? 8'h86 : 8'hC0;
        default: b = 8'hFF;
      endcase
      if (em != 3) b[7] = ~dp[i];
      e.segs[8*i +: 8] = b;
    end
    return e;
  endfunction

  task automatic drive(input bit s, input longint v, input int m, input logic [7:0] dp, input bit lz);
    logic [1:0] mm;
    mm = m[1:0];
    @(negedge clk);
    if (!s) begin
      ifa.load = 1'b1; ifa.value = 14'(v); ifa.mode = mode_e'(mm);
      ifa.dp_mask = dp[3:0]; ifa.lz_blank = lz;
    end else begin
      ifb.load = 1'b1; ifb.value = 20'(v); ifb.mode = mode_e'(mm);
      ifb.dp_mask = dp[5:0]; ifb.lz_blank = lz;
    end
    @(negedge clk);
    ifa.load = 1'b0;
    ifb.load = 1'b0;
  endtask

  task automatic wait_idle(input bit s);
    int k;
    k = 0;
    while ((s ? ifb.busy : ifa.busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("busy_timeout", (k >= 200) ? 1 : 0, 0);
    repeat (32) @(negedge clk);
  endtask

  task automatic xact(input bit s, input longint v, input int m, input logic [7:0] dp, input bit lz);
    sb.push_back(model(s ? 6 : 4, v, m, dp, lz));
    drive(s, v, m, dp, lz);
    wait_idle(s);
  endtask

  // Monitor: busy length and overflow on each commit, then every digit seen during one full scan.
  initial begin : monitor
    logic       b;
    logic       ov;
    logic [7:0] an;
    logic [7:0] sg;
    logic       prev_b;
    int         bcnt;
    int         win;
    int         n;
    int         dw;
    int         idx;
    int         zeros;
    int         prev_idx;
    logic [7:0] prev_an;
    logic [7:0] seen;
    exp_t       cur;
    prev_b = 1'b0; bcnt = 0; win = 0; prev_idx = -1; prev_an = 8'h00; seen = 8'h00; cur = '0;
    forever begin
      @(negedge clk);
      n  = sel ? 6 : 4;
      dw = sel ? 20 : 14;
      b  = sel ? ifb.busy : ifa.busy;
      ov = sel ? ifb.overflow : ifa.overflow;
      an = sel ? {2'b11, ifb.anodes} : {4'hF, ifa.anodes};
      sg = sel ? ifb.segments : ifa.segments;
      if (!rst_n) begin
        prev_b = 1'b0; bcnt = 0; win = 0;
      end else begin
        if (b) bcnt++;
        if (prev_b && !b) begin
          chk("busy_len", bcnt, dw + 1);
          if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
          end else begin
            cur = sb.pop_front();
            chk("overflow", ov, cur.ovf);
            win = n * 4 + 6; seen = 8'h00; prev_an = 8'h00; prev_idx = -1;
          end
        end
        if (!b) bcnt = 0;
        if (win > 0) begin
          win--;
          if (an != prev_an) begin
            zeros = 0; idx = 0;
            for (int i = 0; i < 8; i++) begin
              if (!an[i]) begin zeros++; idx = i; end
            end
            if (zeros != 1) begin
              chk("anodes_onecold", zeros, 1);
            end else begin
              chk($sformatf("digit%0d", idx), sg, cur.segs[8*idx +: 8]);
              if (prev_idx >= 0) chk("scan_order", idx, (prev_idx + 1) % n);
              seen[idx] = 1'b1;
              prev_idx = idx;
            end
            prev_an = an;
          end
          if (win == 0) chk("scan_cover", seen, (1 << n) - 1);
        end
        prev_b = b;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    total = 0; bad = 0; sel = 1'b0;
    rst_n = 1'b0;
    ifa.load = 1'b0; ifa.value = '0; ifa.mode = MODE_PLAIN; ifa.dp_mask = '0; ifa.lz_blank = 1'b0;
    ifb.load = 1'b0; ifb.value = '0; ifb.mode = MODE_PLAIN; ifb.dp_mask = '0; ifb.lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_anodes_a", ifa.anodes, 4'hF);
    chk("rst_seg_a", ifa.segments, 8'hFF);
    chk("rst_busy_a", ifa.busy, 0);
    chk("rst_ovf_a", ifa.overflow, 0);
    chk("rst_anodes_b", ifb.anodes, 6'h3F);
    chk("rst_seg_b", ifb.segments, 8'hFF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 4-digit instance: directed cases
    xact(0, 1234, 0, 8'h00, 1'b0);
    xact(0, 7, 1, 8'h00, 1'b1);
    xact(0, 7, 1, 8'h00, 1'b0);
    xact(0, 10000, 0, 8'h00, 1'b0);
    xact(0, 5, 0, 8'h00, 1'b0);
    sb.push_back(model(4, 42, 0, 8'h04, 1'b0));
    drive(0, 42, 0, 8'h04, 1'b0);
    repeat (3) @(negedge clk);
    drive(0, 99, 0, 8'h00, 1'b0);
    wait_idle(0);
    xact(0, 0, 0, 8'h00, 1'b1);
    xact(0, 1000, 1, 8'h00, 1'b1);
    xact(0, 999, 1, 8'h09, 1'b1);
    xact(0, 9999, 0, 8'h0F, 1'b1);
    xact(0, 123, 2, 8'h02, 1'b0);
    xact(0, 88, 3, 8'h0F, 1'b0);
    for (int i = 0; i < 16; i++) begin
      xact(0, longint'($urandom_range(0, 16383)), int'($urandom_range(0, 3)),
           8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // 6-digit instance
    sel = 1'b1;
    repeat (2) @(negedge clk);
    xact(1, 999999, 0, 8'h00, 1'b0);
    xact(1, 100000, 1, 8'h00, 1'b1);
    xact(1, 99999, 1, 8'h20, 1'b1);
    xact(1, 1000000, 0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      xact(1, longint'($urandom_range(0, 1048575)), int'($urandom_range(0, 3)),
           8'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a conversion
    drive(1, 123456, 0, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    chk("busy_before_abort", ifb.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", ifb.busy, 0);
    chk("abort_seg", ifb.segments, 8'hFF);
    chk("abort_anodes", ifb.anodes, 6'h3F);
    chk("abort_ovf", ifb.overflow, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Parametrised successor to the calculator's 4-digit multiplexed 7-segment driver. It accepts an unsigned magnitude plus a display mode through a load/busy handshake. A sequential double-dabble converter turns the magnitude into BCD, and the block scans N_DIGITS common-anode digits with leading-zero blanking, a floating minus sign, per-digit decimal points and overflow detection. It sits between the ALU/switch-select logic and the board pins.

Parameters:
N_DIGITS, 4, number of digits scanned (2..8)
DATA_W, 14, magnitude width; must satisfy 2^DATA_W >= 10^N_DIGITS
DIV_W, 12, refresh divider width; one scan step every 2^DIV_W clocks

Ports:
Clk  in  1  system clock
Rst_n  in  1  synchronous reset, active-low
load  in  1  one-cycle strobe; capture inputs when busy=0
value  in  DATA_W  unsigned magnitude to display
mode  in  2  0 plain, 1 negative, 2 error, 3 blank
dp_mask  in  N_DIGITS  bit i lights the DP of digit i (digit 0 = rightmost)
lz_blank  in  1  suppress leading zeros
busy  out  1  conversion in progress
overflow  out  1  last accepted value did not fit
anodes  out  N_DIGITS  one-cold, active-low digit enables
segments  out  8  active-low {dp,g,f,e,d,c,b,a}

Behaviour:
- Rst_n=0 on a Clk edge: anodes all 1, segments 8'hFF, busy 0, overflow 0, scan index 0, divider 0, displayed mode = blank. Reset aborts any conversion in progress.
- Handshake: load with busy=0 latches value, mode, dp_mask and lz_blank. busy rises the next cycle and stays high for exactly DATA_W+1 cycles: DATA_W shift/add-3 steps, then one commit cycle.
- While busy, load is ignored and the previous image keeps being displayed. On commit, BCD digits, mode, dp_mask, lz_blank and overflow update atomically.
- Overflow:
  - mode 0: value > 10^N_DIGITS-1 sets overflow.
  - mode 1: value > 10^(N_DIGITS-1)-1 sets overflow.
  - On overflow the displayed mode becomes error. The flag holds until the next accepted load.
- Scan:
  - Divider counts every clock. When it wraps from all-ones to 0, the scan index increments.
  - The index wraps from N_DIGITS-1 to 0, including non-power-of-two N_DIGITS.
  - anodes = ~(1<<index). segments are registered in the same cycle from the same index, so there is no one-digit lag.
- Digit image per mode:
  - plain: BCD digit glyph (0..9: C0,F9,A4,B0,99,92,82,F8,80,90).
  - negative: digits as plain. Minus (BF) goes on digit N_DIGITS-1 when lz_blank=0. When lz_blank=1 it goes on the first blanked position left of the most significant non-zero digit.
  - error: digit 0 = 'E' (86), other digits '0' (C0).
  - blank: all digits FF, DP forced off.
- Leading-zero blanking: digits above the most significant non-zero digit show FF. Digit 0 is never blanked, so value 0 shows "0".
- DP: segments[7] = ~dp_mask[index] in every mode except blank, and it is applied after blanking.
- BCD digits are 4 bits each. The converter's internal register is DATA_W + 4*N_DIGITS bits wide. No arithmetic result is truncated silently; overflow is flagged instead.

Decomposition:
- Package seg_pkg holds:
  - mode codes MODE_PLAIN, MODE_NEG, MODE_ERR, MODE_BLANK
  - segment constants SEG_BLANK=8'hFF, SEG_MINUS=8'hBF, SEG_E=8'h86
  - function digit_to_seg(4-bit) -> 7-bit
  - function pow10(n) for overflow limits
- Sub-module bin2bcd_seq does the sequential double-dabble. Its interface is Clk, Rst_n, start, bin, busy, done and bcd[4*N_DIGITS]. seg_display_ctrl owns the handshake, overflow check, image build and scan.

Test Plan:
1. Hold Rst_n=0 for 3 cycles -> anodes=4'hF, segments=FF, busy=0, overflow=0.
2. DIV_W=2, load value=1234, mode=0 -> busy high 15 cycles. Then anodes E,D,B,7 show segments 99,B0,A4,F9 respectively.
3. value=7, mode=1, lz_blank=1 -> digit0=F8, digit1=BF, digits2-3=FF. Same with lz_blank=0 -> digit3=BF, digits1-2=C0.
4. value=10000, mode=0 -> overflow=1, digit0=86, digits1-3=C0. A following load of 5 clears overflow.
5. Load 42, then pulse load with 99 while busy -> 99 is ignored and 42 is shown. dp_mask=4'b0100 -> digit2 segment bit7=0, others bit7=1.
6. N_DIGITS=6, DATA_W=20, value=999999 -> six 90 digits, scan index wraps 5->0. Rst_n low mid-conversion -> busy=0 and all segments FF next cycle.
